// File: rtl/timer_ctrl.sv
// Sequencing controller for an external up-counter: one-shot or periodic
// timing against a latched limit, with pause/resume/abort and a period tally.
module timer_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_clr,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] periods
);

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        RUN,
        PAUSE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic             mode_q;
    logic [WIDTH-1:0] limit_q;
    logic             match;
    logic             load;
    logic             tally;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            limit_q <= '0;
            periods <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                mode_q  <= mode;
                limit_q <= limit;
                periods <= '0;
            end else if (tally) begin
                periods <= periods + WIDTH'(1);
            end
        end
    end

    // >= rather than == so an overshooting or corrupted counter still terminates
    assign match = (state == RUN) && (cnt_value >= limit_q);

    always_comb begin
        state_n = state;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        busy    = (state != IDLE);
        done    = 1'b0;
        err     = 1'b0;
        load    = 1'b0;
        tally   = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (limit != '0) begin
                        load    = 1'b1;
                        state_n = CLEAR;
                    end else begin
                        err = 1'b1;
                    end
                end
            end
            CLEAR: begin
                cnt_clr = 1'b1;
                state_n = RUN;
            end
            RUN: begin
                if (match) begin
                    done  = 1'b1;
                    tally = 1'b1;
                    if (mode_q) begin
                        cnt_clr = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    // the counter still advances on the cycle stop is seen
                    cnt_en = 1'b1;
                    if (stop) begin
                        state_n = PAUSE;
                    end
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (start) begin
                    state_n = RUN;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: drives a behavioural counter, queues expected outputs
// from a flag-based reference model, and compares them in a separate monitor.
module tb_timer_ctrl;

    typedef struct packed {
        logic       en;
        logic       clr;
        logic       busy;
        logic       done;
        logic       err;
        logic [7:0] periods;
        logic [7:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode = 1'b0;
    logic [7:0] limit = 8'd0;
    logic [7:0] cnt = 8'd77;
    logic       cnt_en;
    logic       cnt_clr;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] periods;

    int checks = 0;
    int errors = 0;
    obs_t exp_q[$];

    // reference model state
    bit       m_clear = 0;
    bit       m_run = 0;
    bit       m_pause = 0;
    bit       m_periodic = 0;
    bit [7:0] m_lim = 0;
    bit [7:0] m_per = 0;
    bit [7:0] m_cnt = 8'd77;

    timer_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
        .limit(limit), .cnt_value(cnt), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
        .busy(busy), .done(done), .err(err), .periods(periods)
    );

    always #5 clk = ~clk;

    // the controlled counter
    always @(posedge clk) begin
        if (cnt_clr) cnt <= 8'd0;
        else if (cnt_en) cnt <= cnt + 8'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // monitor: one expected observation per cycle, sampled on the falling edge
    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = '{en: cnt_en, clr: cnt_clr, busy: busy, done: done, err: err,
                  periods: periods, cnt: cnt};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle@%0t: got en=%b clr=%b busy=%b done=%b err=%b per=%0d cnt=%0d expected en=%b clr=%b busy=%b done=%b err=%b per=%0d cnt=%0d",
                         $time, a.en, a.clr, a.busy, a.done, a.err, a.periods, a.cnt,
                         e.en, e.clr, e.busy, e.done, e.err, e.periods, e.cnt);
            end
        end
    end

    task automatic model_reset();
        m_clear = 0; m_run = 0; m_pause = 0; m_periodic = 0; m_lim = 0; m_per = 0;
    endtask

    // Apply inputs for one cycle, queue the expected observation, advance the model.
    task automatic cyc(input bit s, input bit p, input bit m, input bit [7:0] l);
        obs_t e;
        bit active, hit;
        @(posedge clk); #1;
        start = s; stop = p; mode = m; limit = l;
        active = m_clear || m_run || m_pause;
        hit = m_run && (m_cnt >= m_lim);
        e.busy = active;
        e.clr = m_clear || (hit && m_periodic);
        e.en = m_run && !hit;
        e.done = hit;
        e.err = !active && s && (l == 0);
        e.periods = m_per;
        e.cnt = m_cnt;
        exp_q.push_back(e);
        if (e.clr) m_cnt = 0;
        else if (e.en) m_cnt = m_cnt + 1;
        if (!active) begin
            if (s && l != 0) begin
                m_clear = 1; m_lim = l; m_periodic = m; m_per = 0;
            end
        end else if (m_clear) begin
            m_clear = 0; m_run = 1;
        end else if (m_run) begin
            if (hit) begin
                m_per = m_per + 1;
                if (!m_periodic) m_run = 0;
            end else if (p) begin
                m_run = 0; m_pause = 1;
            end
        end else begin
            if (p) m_pause = 0;
            else if (s) begin m_pause = 0; m_run = 1; end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 8'd0);
    endtask

    // Reset pulsed between edges while running; outputs must drop at once.
    task automatic mid_reset();
        @(posedge clk); #1;
        start = 0; stop = 0;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_en", cnt_en, m_run && (m_cnt < m_lim));
        #2 reset = 1;
        #1;
        chk("rst_en", cnt_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_periods", periods, 0);
        chk("rst_clr", cnt_clr, 0);
        model_reset();
        exp_q.push_back('{en: 0, clr: 0, busy: 0, done: 0, err: 0, periods: 0, cnt: m_cnt});
        reset = 0;
    endtask

    initial begin
        #2;
        chk("init_en", cnt_en, 0);
        chk("init_clr", cnt_clr, 0);
        chk("init_busy", busy, 0);
        chk("init_done", done, 0);
        chk("init_err", err, 0);
        chk("init_periods", periods, 0);
        #10 reset = 0;

        // one-shot, limit 3
        cyc(1, 0, 0, 8'd3);
        idle(7);
        // periodic, limit 2, then pause and abort
        cyc(1, 0, 1, 8'd2);
        idle(13);
        cyc(0, 1, 0, 8'd0);
        cyc(0, 1, 0, 8'd0);
        idle(2);
        // pause at 2, hold, resume, limit 5 one-shot
        cyc(1, 0, 0, 8'd5);
        idle(3);
        cyc(0, 1, 0, 8'd0);
        idle(4);
        cyc(1, 0, 0, 8'd0);
        idle(4);
        // abort with start and stop together in pause
        cyc(1, 0, 1, 8'd4);
        idle(3);
        cyc(0, 1, 0, 8'd0);
        idle(1);
        cyc(1, 1, 0, 8'd0);
        idle(3);
        // stop coincident with match in periodic mode; limit change while busy
        cyc(1, 0, 1, 8'd2);
        idle(3);
        cyc(0, 1, 0, 8'd9);
        idle(3);
        cyc(0, 1, 0, 8'd0);
        cyc(0, 1, 0, 8'd0);
        // rejected start
        cyc(1, 0, 0, 8'd0);
        idle(2);
        // reset mid-run, then limit 1
        cyc(1, 0, 1, 8'd6);
        idle(4);
        mid_reset();
        cyc(1, 0, 0, 8'd1);
        idle(5);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit s, p, m;
            bit [7:0] l;
            s = ($urandom_range(0, 7) == 0);
            p = ($urandom_range(0, 11) == 0);
            m = $urandom_range(0, 1);
            l = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
            cyc(s, p, m, l);
        end
        idle(1);
        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
